alu_pipe: RTL and testbench

- Parametrised successor to the team's 8-bit single-function ALU.
- Adds the following:
  - configurable data width
  - valid/ready handshakes on both input and output, with backpressure
  - a registered result with N/Z/C/V status flags
  - optional signed saturation
  - an iterative shift-add multiplier that takes multiple cycles
- Sits between an operand-issue stage and a result consumer in the datapath.

---
 rtl/alu_pipe.sv | 137 +++++++++++++
 tb/tb_alu_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshakes on both sides, registered result and
// {N,Z,C,V} flags, optional signed saturation and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH    = 8,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_lhs,
  input  logic [WIDTH-1:0] in_rhs,
  input  logic [2:0]       in_function,
  output logic             out_valid,
  input  logic             in_result_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [WIDTH-1:0]     mplier_reg;
  logic [SW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   prod_next;

  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [WIDTH:0]       shl_full;
  logic [SW-1:0]        shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  assign out_ready = in_reset_n && (state_reg == IDLE) && (!out_valid || in_result_ready);

  always_comb begin
    shamt    = in_rhs[SW-1:0];
    add_full = {1'b0, in_lhs} + {1'b0, in_rhs};
    // Adding the two's complement of rhs leaves carry set exactly when lhs >= rhs.
    sub_full = {1'b0, in_lhs} + {1'b0, ~in_rhs} + (WIDTH+1)'(1);
    shl_full = {1'b0, in_lhs} << shamt;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (in_function)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (in_lhs[WIDTH-1] == in_rhs[WIDTH-1]) && (alu_res[WIDTH-1] != in_lhs[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (in_lhs[WIDTH-1] != in_rhs[WIDTH-1]) && (alu_res[WIDTH-1] != in_lhs[WIDTH-1]);
      end
      OP_AND: alu_res = in_lhs & in_rhs;
      OP_OR:  alu_res = in_lhs | in_rhs;
      OP_XOR: alu_res = in_lhs ^ in_rhs;
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      OP_SHR: alu_res = in_lhs >> shamt;
      default: alu_res = '0;
    endcase
    // Overflow direction follows the lhs sign for both ADD and SUB.
    if (SAT_MODE && alu_v) begin
      alu_res = in_lhs[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (out_valid && in_result_ready) begin
            out_valid <= 1'b0;
          end
          if (in_valid && out_ready) begin
            if (in_function == OP_MUL) begin
              state_reg  <= MUL;
              mcand_reg  <= {{WIDTH{1'b0}}, in_lhs};
              mplier_reg <= in_rhs;
              prod_reg   <= '0;
              count_reg  <= '0;
              out_valid  <= 1'b0;
            end else begin
              out_valid  <= 1'b1;
              out_result <= alu_res;
              out_flags  <= {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
            end
          end
        end
        MUL: begin
          prod_reg   <= prod_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + SW'(1);
          if (count_reg == SW'(WIDTH-1)) begin
            state_reg  <= IDLE;
            out_valid  <= 1'b1;
            out_result <= prod_next[WIDTH-1:0];
            out_flags  <= {prod_next[WIDTH-1], prod_next[WIDTH-1:0] == '0, 1'b0,
                           |prod_next[2*WIDTH-1:WIDTH]};
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed plan plus random ops, two instances (no saturation / saturation)
// fed the same stimulus and compared against an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] lhs, rhs;
  logic [2:0] fn;
  logic       rr;
  logic       ready0, ready1, ov0, ov1;
  logic [7:0] res0, res1;
  logic [3:0] fl0, fl1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(8), .SAT_MODE(1'b0)) dut0 (
    .in_clock(clk), .in_reset_n(rst_n), .in_valid(in_valid), .out_ready(ready0),
    .in_lhs(lhs), .in_rhs(rhs), .in_function(fn), .out_valid(ov0),
    .in_result_ready(rr), .out_result(res0), .out_flags(fl0));

  alu_pipe #(.WIDTH(8), .SAT_MODE(1'b1)) dut1 (
    .in_clock(clk), .in_reset_n(rst_n), .in_valid(in_valid), .out_ready(ready1),
    .in_lhs(lhs), .in_rhs(rhs), .in_function(fn), .out_valid(ov1),
    .in_result_ready(rr), .out_result(res1), .out_flags(fl1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {flags, result} from plain integer arithmetic on the opcode rules.
  function automatic logic [11:0] model(input int f, input int a, input int b, input bit sat);
    int r, c, v, sa, sb, s, sh, p;
    logic n, z;
    c = 0; v = 0; r = 0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    sh = b % 8;
    case (f)
      0: begin r = a + b; c = (r >= 256); s = sa + sb; v = (s > 127 || s < -128);
               if (sat && v) r = (s > 127) ? 127 : 128; end
      1: begin r = a - b; c = (a >= b); s = sa - sb; v = (s > 127 || s < -128);
               if (sat && v) r = (s > 127) ? 127 : 128; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << sh; c = (sh == 0) ? 0 : ((a >> (8 - sh)) & 1); end
      6: r = a >> sh;
      default: begin p = a * b; r = p; v = (p > 255); end
    endcase
    r = r & 255;
    n = r[7];
    z = (r == 0);
    return {n, z, c[0], v[0], r[7:0]};
  endfunction

  task automatic do_op(input string tag, input int f, input int a, input int b);
    logic [11:0] e0, e1;
    int waited;
    e0 = model(f, a, b, 1'b0);
    e1 = model(f, a, b, 1'b1);
    waited = 0;
    while (!ready0 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk({tag, "_ready"}, ready0, 1);
    in_valid = 1'b1; fn = 3'(f); lhs = 8'(a); rhs = 8'(b);
    @(posedge clk); #1;
    in_valid = 1'b0; lhs = 8'($urandom); rhs = 8'($urandom); fn = 3'($urandom);
    if (f == 7) begin
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_mulbusy_valid"}, ov0, 0);
        chk({tag, "_mulbusy_ready"}, ready0, 0);
        @(posedge clk); #1;
      end
    end
    chk({tag, "_valid"}, {ov0, ov1}, 2'b11);
    chk({tag, "_res0"}, res0, e0[7:0]);
    chk({tag, "_fl0"}, fl0, e0[11:8]);
    chk({tag, "_res1"}, res1, e1[7:0]);
    chk({tag, "_fl1"}, fl1, e1[11:8]);
    $display("op %s f=%0d a=%02h b=%02h -> r0=%02h f0=%b r1=%02h f1=%b", tag, f, a, b, res0, fl0, res1, fl1);
  endtask

  initial begin
    logic [7:0] hold_res;
    logic [3:0] hold_fl;
    rst_n = 1'b0; in_valid = 1'b0; lhs = '0; rhs = '0; fn = '0; rr = 1'b1;
    #12;
    chk("rst_valid", ov0, 0);
    chk("rst_result", res0, 0);
    chk("rst_flags", fl0, 0);
    chk("rst_ready", ready0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", ready0, 1);

    do_op("add19_7", 0, 19, 7);
    chk("add19_7_const", {fl0, res0}, 12'h01A);
    do_op("sub7_19", 1, 7, 19);
    chk("sub7_19_const", {fl0, res0}, 12'h8F4);
    do_op("sub19_19", 1, 19, 19);
    chk("sub19_19_const", {fl0, res0}, 12'h600);
    do_op("add7f_1", 0, 'h7F, 1);
    chk("add7f_1_nosat", {fl0, res0}, 12'h980);
    chk("add7f_1_sat", {fl1, res1}, 12'h17F);
    do_op("subsat", 1, 'h80, 1);
    do_op("shl81_1", 5, 'h81, 1);
    chk("shl81_1_const", {fl0, res0}, 12'h202);
    do_op("shl_by0", 5, 'hC3, 8);
    do_op("mul19_7", 7, 19, 7);
    chk("mul19_7_const", {fl0, res0}, 12'h885);
    do_op("mul10_10", 7, 'h10, 'h10);
    chk("mul10_10_const", {fl0, res0}, 12'h500);

    // Backpressure: drain, issue with consumer stalled, then release with a queued XOR.
    @(posedge clk); #1;
    chk("drained", ov0, 0);
    rr = 1'b0;
    do_op("bp_add", 0, 'h30, 'h05);
    hold_res = res0; hold_fl = fl0;
    in_valid = 1'b1; fn = 3'd4; lhs = 8'hF0; rhs = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", ov0, 1);
      chk("bp_hold_res", res0, hold_res);
      chk("bp_hold_flags", fl0, hold_fl);
      chk("bp_hold_ready", ready0, 0);
    end
    rr = 1'b1;
    #1;
    chk("bp_release_ready", ready0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_xor", {ov0, fl0, res0}, 13'h18FF);
    $display("op bp_xor -> r0=%02h f0=%b", res0, fl0);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; fn = 3'd7; lhs = 8'd19; rhs = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midmul_rst_valid", ov0, 0);
    chk("midmul_rst_result", res0, 0);
    chk("midmul_rst_ready", ready0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("after_rst_ready", ready0, 1);
    do_op("add1_1", 0, 1, 1);
    chk("add1_1_const", res0, 8'h02);
    $display("op midmul_reset -> recovered r0=%02h", res0);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        rr = 1'b0;
        hold_res = res0; hold_fl = fl0;
        repeat (2) begin
          @(posedge clk); #1;
          chk("rand_hold", {ov0, ready0, fl0, res0}, {2'b10, hold_fl, hold_res});
        end
        rr = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
